// File: rtl/pll_lock_rst_gen_if.sv
// Signal bundle between the PLL lock/reset generator and its surroundings.
// slave: generator side (lock/request in, resets/status out); master: the driver side.
interface pll_lock_rst_gen_if;
   logic       pll_lock;
   logic       ext_rst_req;
   logic       sys_rst;
   logic       sys_rst_n;
   logic       rst_done;
   logic       pll_rst_req;
   logic [7:0] lock_loss_cnt;
   logic [1:0] dbg_state;

   modport slave (
      input  pll_lock,
      input  ext_rst_req,
      output sys_rst,
      output sys_rst_n,
      output rst_done,
      output pll_rst_req,
      output lock_loss_cnt,
      output dbg_state
   );

   modport master (
      output pll_lock,
      output ext_rst_req,
      input  sys_rst,
      input  sys_rst_n,
      input  rst_done,
      input  pll_rst_req,
      input  lock_loss_cnt,
      input  dbg_state
   );
endinterface

// File: rtl/pll_lock_rst_gen.sv
// PLL lock debouncer and system reset generator; pulses PLL RST on timeout.
// Ports: clk (free-running ref clock), rst (sync active-high), bus (slave modport).
module pll_lock_rst_gen #(
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOSS_TOL_CYCLES     = 4,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int PLL_RST_CYCLES      = 64
) (
   input logic               clk,
   input logic               rst,
   pll_lock_rst_gen_if.slave bus
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2,
      PLLRST    = 2'd3
   } state_t;

   localparam logic [23:0] STAB_LAST = 24'(LOCK_STABLE_CYCLES - 1);
   localparam logic [23:0] TMO_LAST  = 24'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  LOSS_LAST = 8'(LOSS_TOL_CYCLES - 1);
   localparam logic [7:0]  PRST_LAST = 8'(PLL_RST_CYCLES - 1);

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic [23:0] stab_cnt_q, stab_cnt_d;
   logic [23:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]  loss_cnt_q, loss_cnt_d;
   logic [7:0]  prst_cnt_q, prst_cnt_d;
   logic [7:0]  lock_loss_cnt_q, lock_loss_cnt_d;
   logic        sys_rst_q, sys_rst_d;
   logic        sys_rst_n_q, sys_rst_n_d;
   logic        rst_done_q, rst_done_d;
   logic        pll_rst_req_q, pll_rst_req_d;
   logic        lock_s;

   assign lock_s = sync2_q;

   always_comb begin
      state_d         = state_q;
      sync1_d         = bus.pll_lock;
      sync2_d         = sync1_q;
      stab_cnt_d      = stab_cnt_q;
      tmo_cnt_d       = tmo_cnt_q;
      loss_cnt_d      = loss_cnt_q;
      prst_cnt_d      = prst_cnt_q;
      lock_loss_cnt_d = lock_loss_cnt_q;
      rst_done_d      = 1'b0;

      unique case (state_q)
         WAIT_LOCK: begin
            if (tmo_cnt_q == TMO_LAST) begin
               state_d    = PLLRST;
               prst_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 24'd1;
               if (lock_s) begin
                  state_d    = STABLE;
                  stab_cnt_d = '0;
               end
            end
         end
         STABLE: begin
            // Reaching RUN beats a coincident timeout.
            if (lock_s && stab_cnt_q == STAB_LAST) begin
               state_d    = RUN;
               tmo_cnt_d  = '0;
               loss_cnt_d = '0;
               rst_done_d = 1'b1;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d    = PLLRST;
               prst_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 24'd1;
               if (!lock_s) begin
                  state_d    = WAIT_LOCK;
                  stab_cnt_d = '0;
               end else begin
                  stab_cnt_d = stab_cnt_q + 24'd1;
               end
            end
         end
         RUN: begin
            if (!lock_s && loss_cnt_q == LOSS_LAST) begin
               state_d    = WAIT_LOCK;
               loss_cnt_d = '0;
               if (lock_loss_cnt_q != 8'hff) begin
                  lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
               end
            end else begin
               loss_cnt_d = lock_s ? 8'd0 : loss_cnt_q + 8'd1;
               if (bus.ext_rst_req) begin
                  state_d    = STABLE;
                  stab_cnt_d = '0;
               end
            end
         end
         PLLRST: begin
            if (prst_cnt_q == PRST_LAST) begin
               state_d   = WAIT_LOCK;
               tmo_cnt_d = '0;
            end else begin
               prst_cnt_d = prst_cnt_q + 8'd1;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase

      // Outputs are registered from the next state so they change with it.
      sys_rst_d     = (state_d != RUN);
      sys_rst_n_d   = (state_d == RUN);
      pll_rst_req_d = (state_d == PLLRST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= WAIT_LOCK;
         sync1_q         <= 1'b0;
         sync2_q         <= 1'b0;
         stab_cnt_q      <= '0;
         tmo_cnt_q       <= '0;
         loss_cnt_q      <= '0;
         prst_cnt_q      <= '0;
         lock_loss_cnt_q <= '0;
         sys_rst_q       <= 1'b1;
         sys_rst_n_q     <= 1'b0;
         rst_done_q      <= 1'b0;
         pll_rst_req_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         stab_cnt_q      <= stab_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         loss_cnt_q      <= loss_cnt_d;
         prst_cnt_q      <= prst_cnt_d;
         lock_loss_cnt_q <= lock_loss_cnt_d;
         sys_rst_q       <= sys_rst_d;
         sys_rst_n_q     <= sys_rst_n_d;
         rst_done_q      <= rst_done_d;
         pll_rst_req_q   <= pll_rst_req_d;
      end
   end

   assign bus.sys_rst       = sys_rst_q;
   assign bus.sys_rst_n     = sys_rst_n_q;
   assign bus.rst_done      = rst_done_q;
   assign bus.pll_rst_req   = pll_rst_req_q;
   assign bus.lock_loss_cnt = lock_loss_cnt_q;
   assign bus.dbg_state     = state_q;

endmodule
